// File: rtl/xif_result_buffer_if.sv
// CORE-V-XIF commit, result-in and result-out signal bundle for xif_result_buffer.
// slave is the buffer's view; master is the view of the core/coprocessor side.
interface xif_result_buffer_if #(
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
);
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [ID_WIDTH-1:0] in_id_i;
  logic [XLEN-1:0]     in_data_i;
  logic [4:0]          in_rd_i;
  logic                in_we_i;
  logic                in_exc_i;
  logic [5:0]          in_exccode_i;

  logic                out_valid_o;
  logic                out_ready_i;
  logic [ID_WIDTH-1:0] out_id_o;
  logic [XLEN-1:0]     out_data_o;
  logic [4:0]          out_rd_o;
  logic                out_we_o;
  logic                out_exc_o;
  logic [5:0]          out_exccode_o;

  modport slave (
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i, in_exccode_i,
    output in_ready_o,
    input  out_ready_i,
    output out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o
  );

  modport master (
    output commit_valid_i, commit_id_i, commit_kill_i,
    output in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i, in_exccode_i,
    input  in_ready_o,
    output out_ready_i,
    input  out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o
  );
endinterface

// File: rtl/xif_result_buffer.sv
// In-order result FIFO that releases a coprocessor result only once its ID is committed
// and silently drops results whose ID was killed.
module xif_result_buffer #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  xif_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NID = 1 << ID_WIDTH;

  logic [ID_WIDTH-1:0] r_id      [DEPTH];
  logic [XLEN-1:0]     r_data    [DEPTH];
  logic [4:0]          r_rd      [DEPTH];
  logic                r_we      [DEPTH];
  logic                r_exc     [DEPTH];
  logic [5:0]          r_exccode [DEPTH];
  logic [DEPTH-1:0]    r_vld;

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [NID-1:0]      r_c;
  logic [NID-1:0]      r_k;
  logic                r_err;

  logic                w_head_vld;
  logic [ID_WIDTH-1:0] w_head_id;
  logic                w_drop;
  logic                w_out_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_id_hit;
  logic                w_cmt_dup;

  assign w_head_vld  = (r_count != '0);
  assign w_head_id   = r_id[r_rd_ptr];
  assign w_drop      = w_head_vld && r_k[w_head_id];
  assign w_out_valid = w_head_vld && r_c[w_head_id] && !r_k[w_head_id];
  assign w_pop       = w_drop || (w_out_valid && bus.out_ready_i);

  assign bus.in_ready_o = (r_count < CW'(DEPTH));
  assign w_push         = bus.in_valid_i && bus.in_ready_o;

  // Data fields read as zero whenever nothing is being presented.
  assign bus.out_valid_o   = w_out_valid;
  assign bus.out_id_o      = w_out_valid ? w_head_id            : '0;
  assign bus.out_data_o    = w_out_valid ? r_data[r_rd_ptr]     : '0;
  assign bus.out_rd_o      = w_out_valid ? r_rd[r_rd_ptr]       : '0;
  assign bus.out_we_o      = w_out_valid ? r_we[r_rd_ptr]       : 1'b0;
  assign bus.out_exc_o     = w_out_valid ? r_exc[r_rd_ptr]      : 1'b0;
  assign bus.out_exccode_o = w_out_valid ? r_exccode[r_rd_ptr]  : '0;

  assign count_o = r_count;
  assign err_o   = r_err;

  always_comb begin
    w_id_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (r_vld[j] && (r_id[j] == bus.in_id_i)) w_id_hit = 1'b1;
    end
  end

  assign w_cmt_dup = bus.commit_valid_i && (r_c[bus.commit_id_i] || r_k[bus.commit_id_i]);

  // Payload storage carries no reset; occupancy is tracked by r_vld/r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id[r_wr_ptr]      <= bus.in_id_i;
      r_data[r_wr_ptr]    <= bus.in_data_i;
      r_rd[r_wr_ptr]      <= bus.in_rd_i;
      r_we[r_wr_ptr]      <= bus.in_we_i;
      r_exc[r_wr_ptr]     <= bus.in_exc_i;
      r_exccode[r_wr_ptr] <= bus.in_exccode_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_cmt_dup || (w_push && w_id_hit)) r_err <= 1'b1;
    end
  end

  // A commit/kill landing on the ID being popped wins over the pop's clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c <= '0;
      r_k <= '0;
    end else begin
      for (int i = 0; i < NID; i++) begin
        if (w_pop && (w_head_id == ID_WIDTH'(i))) begin
          r_c[i] <= 1'b0;
          r_k[i] <= 1'b0;
        end
        if (bus.commit_valid_i && (bus.commit_id_i == ID_WIDTH'(i))) begin
          if (bus.commit_kill_i) r_k[i] <= 1'b1;
          else                   r_c[i] <= 1'b1;
        end
      end
    end
  end
endmodule
